// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-core icache/dcache arbiter onto a single RAM port
//
// Grants one cache access at a time to the RAM. Data caches always beat
// instruction caches; between cores, round-robin keyed on the last core served
// for each cache type. One word per grant unless block locking is enabled.
//
// Optional feature macro: ARB_BLOCK_LOCK_EN
//   When defined, a dcache word completed with cctrans[owner]=1 keeps the
//   grant on the same core, so a block transfer is not interleaved.
//   When undefined, cctrans is ignored.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   iREN, iaddr         per-core icache read request and word address
//   iwait, iload        per-core icache stall (low = iload valid) and data
//   dREN, dWEN, cctrans per-core dcache read/write request, block flag
//   daddr, dstore       per-core dcache address and write data
//   dwait, dload        per-core dcache stall (low = access done) and data
//   ramREN, ramWEN      RAM read/write enables
//   ramaddr, ramstore   RAM address and write data
//   ramload, ram_ready  RAM read data and completion strobe

module mem_bus_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0][ADDR_W-1:0]  iload,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0]              cctrans,
    input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
    input  logic [CPUS-1:0][ADDR_W-1:0]  dstore,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][ADDR_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [ADDR_W-1:0]            ramaddr,
    output logic [ADDR_W-1:0]            ramstore,
    input  logic [ADDR_W-1:0]            ramload,
    input  logic                         ram_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   dptr_q,  dptr_d;
    logic   iptr_q,  iptr_d;

    logic [CPUS-1:0] dreq;
    assign dreq = dREN | dWEN;

`ifndef ARB_BLOCK_LOCK_EN
    logic unused_cctrans;
    assign unused_cctrans = ^cctrans;
`endif

    // Both requesting: serve the core that was not served last.
    // Otherwise the sole requester (req[1] selects core 1).
    function automatic logic pick(input logic [1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            dptr_q  <= 1'b1;
            iptr_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dptr_d  = dptr_q;
        iptr_d  = iptr_q;
        case (state_q)
            IDLE: begin
                if (|dreq) begin
                    state_d = DGRANT;
                    owner_d = pick(dreq[1:0], dptr_q);
                end else if (|iREN) begin
                    state_d = IGRANT;
                    owner_d = pick(iREN[1:0], iptr_q);
                end
            end
            DGRANT: begin
                if (!dreq[owner_q]) begin
                    // Abandoned request: release without crediting the core.
                    state_d = IDLE;
                end else if (ram_ready) begin
                    dptr_d = owner_q;
`ifdef ARB_BLOCK_LOCK_EN
                    if (!cctrans[owner_q]) begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            IGRANT: begin
                if (!iREN[owner_q]) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    iptr_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        case (state_q)
            DGRANT: begin
                ramaddr        = daddr[owner_q];
                ramstore       = dstore[owner_q];
                ramWEN         = dWEN[owner_q];
                // Write wins when both enables are raised together.
                ramREN         = dREN[owner_q] & ~dWEN[owner_q];
                dwait[owner_q] = ~ram_ready;
            end
            IGRANT: begin
                ramaddr        = iaddr[owner_q];
                // Gated by the request so an abandoned fetch drives no enable.
                ramREN         = iREN[owner_q];
                iwait[owner_q] = ~ram_ready;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; the wait signals qualify it.
    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            iload[i] = ramload;
            dload[i] = ramload;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        is_d;
        logic        core;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
    } exp_t;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [1:0]        iREN, dREN, dWEN, cctrans;
    logic [1:0][31:0]  iaddr, daddr, dstore;
    logic [1:0]        iwait, dwait;
    logic [1:0][31:0]  iload, dload;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic              ram_ready;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mem_bus_arbiter #(.CPUS(2), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans),
        .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic is_d, input logic core,
                                input logic [31:0] addr, input logic wen,
                                input logic [31:0] data);
        exp_t e;
        e.is_d = is_d; e.core = core; e.addr = addr; e.wen = wen; e.data = data;
        return e;
    endfunction

    // Completion monitor: every low wait pops the scoreboard.
    exp_t        m_e;
    logic        m_isd;
    logic        m_ok;
    logic [31:0] m_load;
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            checks++;
            if (ramREN && ramWEN) begin
                failures++;
                $display("FAIL enables_exclusive ramREN=%b ramWEN=%b", ramREN, ramWEN);
            end
            for (int c = 0; c < 2; c++) begin
                if (dwait[c] === 1'b0 || iwait[c] === 1'b0) begin
                    checks++;
                    m_isd  = (dwait[c] === 1'b0);
                    m_load = m_isd ? dload[c] : iload[c];
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_completion core=%0d is_d=%b addr=%h", c, m_isd, ramaddr);
                    end else begin
                        m_e  = sb.pop_front();
                        m_ok = (m_e.is_d == m_isd) && (m_e.core == c[0]) && (ramaddr == m_e.addr);
                        if (m_isd && m_e.wen)
                            m_ok = m_ok && ramWEN && !ramREN && (ramstore == m_e.data);
                        else
                            m_ok = m_ok && ramREN && !ramWEN && (m_load == m_e.data);
                        if (!m_ok) begin
                            failures++;
                            $display("FAIL completion got core=%0d is_d=%b addr=%h ren=%b wen=%b store=%h load=%h want core=%0d is_d=%b addr=%h wen=%b data=%h",
                                     c, m_isd, ramaddr, ramREN, ramWEN, ramstore, m_load,
                                     m_e.core, m_e.is_d, m_e.addr, m_e.wen, m_e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ram_ready = 1'b0;
    endtask

    task automatic do_reset;
        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        clear_inputs();
        dREN = 2'b11;
        #3;
        checks++;
        if (dwait !== 2'b11 || iwait !== 2'b11 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            failures++;
            $display("FAIL reset_state dwait=%b iwait=%b ren=%b wen=%b required 11 11 0 0",
                     dwait, iwait, ramREN, ramWEN);
        end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h100; ramload = 32'hDEADBEEF;
        sb.push_back(mk(1'b1, 1'b0, 32'h100, 1'b0, 32'hDEADBEEF));
        #1;
        checks++;
        if (dwait !== 2'b11 || ramREN !== 1'b0) begin
            failures++;
            $display("FAIL single_idle dwait=%b ren=%b required 11 0", dwait, ramREN);
        end
        cyc(); #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 2'b11) begin
            failures++;
            $display("FAIL single_grant ren=%b addr=%h dwait=%b required 1 100 11", ramREN, ramaddr, dwait);
        end
        cyc(); ram_ready = 1'b1; #1;
        checks++;
        if (dwait !== 2'b10 || dload[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_done dwait=%b dload0=%h required 10 deadbeef", dwait, dload[0]);
        end
        cyc(); dREN = '0; ram_ready = 1'b0; #1;
        checks++;
        if (dwait !== 2'b11 || ramREN !== 1'b0) begin
            failures++;
            $display("FAIL single_back_idle dwait=%b ren=%b required 11 0", dwait, ramREN);
        end
        drain("single");
    endtask

    task automatic test_alternate;
        logic [1:0] want;
        do_reset();
        dWEN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20;
        dstore[0] = 32'hA0; dstore[1] = 32'hB1; ram_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            sb.push_back(mk(1'b1, i[0], i[0] ? 32'h20 : 32'h10, 1'b1, i[0] ? 32'hB1 : 32'hA0));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            #1;
            want = (k % 4 == 1) ? 2'b10 : (k % 4 == 3) ? 2'b01 : 2'b11;
            checks++;
            if (dwait !== want) begin
                failures++;
                $display("FAIL alternate_k%0d dwait=%b required %b", k, dwait, want);
            end
        end
        cyc(); dWEN = '0; ram_ready = 1'b0;
        drain("alternate");
    endtask

    task automatic test_d_beats_i;
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h200; iREN[1] = 1'b1; iaddr[1] = 32'h300;
        ramload = 32'h12345678; ram_ready = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 32'h200, 1'b0, 32'h12345678));
        sb.push_back(mk(1'b0, 1'b1, 32'h300, 1'b0, 32'h12345678));
        cyc(); #1;
        checks++;
        if (dwait !== 2'b10 || iwait !== 2'b11 || ramaddr !== 32'h200) begin
            failures++;
            $display("FAIL d_first dwait=%b iwait=%b addr=%h required 10 11 200", dwait, iwait, ramaddr);
        end
        cyc(); dREN = '0; #1;
        cyc(); #1;
        checks++;
        if (iwait !== 2'b01 || dwait !== 2'b11 || ramREN !== 1'b1 || ramaddr !== 32'h300) begin
            failures++;
            $display("FAIL i_second iwait=%b dwait=%b ren=%b addr=%h required 01 11 1 300",
                     iwait, dwait, ramREN, ramaddr);
        end
        cyc(); iREN = '0; ram_ready = 1'b0;
        drain("d_beats_i");
    endtask

    task automatic test_write_wins;
        do_reset();
        dREN[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h40; dstore[0] = 32'h55;
        sb.push_back(mk(1'b1, 1'b0, 32'h40, 1'b1, 32'h55));
        cyc(); #1;
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h55 || dwait !== 2'b11) begin
            failures++;
            $display("FAIL write_wins wen=%b ren=%b store=%h dwait=%b required 1 0 55 11",
                     ramWEN, ramREN, ramstore, dwait);
        end
        ram_ready = 1'b1; #1;
        cyc(); dREN = '0; dWEN = '0; ram_ready = 1'b0;
        drain("write_wins");
    endtask

    task automatic test_reset_mid_grant;
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h80;
        cyc(); #1;
        nRST = 1'b0; #1;
        checks++;
        if (dwait !== 2'b11 || iwait !== 2'b11 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            failures++;
            $display("FAIL reset_async dwait=%b iwait=%b ren=%b wen=%b required 11 11 0 0",
                     dwait, iwait, ramREN, ramWEN);
        end
        cyc();
        dREN = 2'b11; daddr[1] = 32'h90; ramload = 32'hCAFE; ram_ready = 1'b1;
        nRST = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 32'h80, 1'b0, 32'hCAFE));
        cyc(); #1;
        checks++;
        if (dwait !== 2'b10 || ramaddr !== 32'h80) begin
            failures++;
            $display("FAIL reset_first_tie dwait=%b addr=%h required 10 80", dwait, ramaddr);
        end
        cyc(); dREN = '0; ram_ready = 1'b0;
        drain("reset_mid");
    endtask

    task automatic test_abort;
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h44;
        cyc(); #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
            failures++;
            $display("FAIL abort_grant ren=%b addr=%h required 1 44", ramREN, ramaddr);
        end
        cyc(); dREN[0] = 1'b0; #1;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 2'b11) begin
            failures++;
            $display("FAIL abort_enables ren=%b wen=%b dwait=%b required 0 0 11", ramREN, ramWEN, dwait);
        end
        cyc();
        dREN = 2'b11; daddr[0] = 32'h33; daddr[1] = 32'h66; ramload = 32'h77; ram_ready = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 32'h33, 1'b0, 32'h77));
        #1;
        checks++;
        if (dwait !== 2'b11 || ramREN !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle dwait=%b ren=%b required 11 0", dwait, ramREN);
        end
        cyc(); #1;
        checks++;
        if (dwait !== 2'b10) begin
            failures++;
            $display("FAIL abort_ptr_kept dwait=%b required 10", dwait);
        end
        cyc(); dREN = '0; ram_ready = 1'b0;
        drain("abort");
    endtask

    task automatic test_cctrans;
        logic [1:0] tbl [5];
        int         drop_k;
        do_reset();
        dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600;
        cctrans[0] = 1'b1; ramload = 32'hBB; ram_ready = 1'b1;
`ifdef ARB_BLOCK_LOCK_EN
        tbl = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01};
        drop_k = 5;
        sb.push_back(mk(1'b1, 1'b0, 32'h500, 1'b0, 32'hBB));
        sb.push_back(mk(1'b1, 1'b0, 32'h500, 1'b0, 32'hBB));
        sb.push_back(mk(1'b1, 1'b1, 32'h600, 1'b0, 32'hBB));
`else
        tbl = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
        drop_k = 4;
        sb.push_back(mk(1'b1, 1'b0, 32'h500, 1'b0, 32'hBB));
        sb.push_back(mk(1'b1, 1'b1, 32'h600, 1'b0, 32'hBB));
`endif
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            if (k == 2) cctrans[0] = 1'b0;
            if (k == drop_k) dREN = '0;
            #1;
            checks++;
            if (dwait !== tbl[k]) begin
                failures++;
                $display("FAIL cctrans_k%0d dwait=%b required %b", k, dwait, tbl[k]);
            end
        end
        cyc(); dREN = '0; ram_ready = 1'b0;
        drain("cctrans");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_d_beats_i();
        test_write_wins();
        test_reset_mid_grant();
        test_abort();
        test_cctrans();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
